// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus bundle between the two data caches and the arbiter.
// Every two-wide vector and two-entry array is indexed 0 = CPU1, 1 = CPU2.
interface snoop_bus_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic [1:0]        req;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic [1:0]        done;
  logic [1:0]        hit;
  logic [DATA_W-1:0] rdata [2];
  logic [1:0]        snoop_valid;
  logic [1:0]        resp_hit;
  logic [1:0]        resp_miss;
  logic [DATA_W-1:0] resp_data [2];
  logic [ADDR_W-1:0] bcast_addr;
  logic [DATA_W-1:0] bcast_data;
  logic              bcast_type;
  logic              busy;

  // The cache side of the bus.
  modport master (
    output req, req_type, req_addr, req_data, resp_hit, resp_miss, resp_data,
    input  done, hit, rdata, snoop_valid, bcast_addr, bcast_data, bcast_type, busy
  );

  // The arbiter side of the bus.
  modport slave (
    input  req, req_type, req_addr, req_data, resp_hit, resp_miss, resp_data,
    output done, hit, rdata, snoop_valid, bcast_addr, bcast_data, bcast_type, busy
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared PE1/PE2 snoop broadcast bus: grant, broadcast, collect the response,
// return completion. Define SNOOP_ARB_STATS_EN to add saturating grant and timeout counters.
module snoop_bus_arbiter #(
  parameter int TIMEOUT_CYC = 16
`ifdef SNOOP_ARB_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  snoop_bus_arbiter_if.slave bus
`ifdef SNOOP_ARB_STATS_EN
  , output logic [STAT_W-1:0] stat_grants_1
  , output logic [STAT_W-1:0] stat_grants_2
  , output logic [STAT_W-1:0] stat_timeouts
`endif
);
  typedef enum logic [1:0] {IDLE, BCAST, WAIT, DONE} state_t;

  localparam int               CNT_W     = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic             owner;  // 0 = CPU1, 1 = CPU2
  logic             ptr;    // requester favoured when both ask at once
  logic [CNT_W-1:0] wait_cnt;
  logic             grant;
  logic             peer;
  logic             peer_hit;
  logic             peer_miss;
  logic [1:0]       owner_sel;

  // NOTE: every always_comb output gets a default first, so no path through the block can infer a latch.
  always_comb begin
    grant = ptr;
    if (bus.req != 2'b11) grant = bus.req[1];
    peer      = ~owner;
    peer_hit  = bus.resp_hit[peer];
    peer_miss = bus.resp_miss[peer];
    owner_sel = owner ? 2'b10 : 2'b01;
  end

  // NOTE: sequential state uses non-blocking assignments so every term reads its pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      owner           <= 1'b0;
      ptr             <= 1'b0;
      wait_cnt        <= '0;
      bus.done        <= '0;
      bus.hit         <= '0;
      bus.rdata[0]    <= '0;
      bus.rdata[1]    <= '0;
      bus.snoop_valid <= '0;
      bus.bcast_addr  <= '0;
      bus.bcast_data  <= '0;
      bus.bcast_type  <= 1'b0;
      bus.busy        <= 1'b0;
`ifdef SNOOP_ARB_STATS_EN
      stat_grants_1   <= '0;
      stat_grants_2   <= '0;
      stat_timeouts   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state           <= BCAST;
            owner           <= grant;
            bus.busy        <= 1'b1;
            bus.snoop_valid <= grant ? 2'b01 : 2'b10;
            bus.bcast_addr  <= bus.req_addr[grant];
            bus.bcast_data  <= bus.req_data[grant];
            bus.bcast_type  <= bus.req_type[grant];
`ifdef SNOOP_ARB_STATS_EN
            if (grant) begin
              if (~&stat_grants_2) stat_grants_2 <= stat_grants_2 + 1'b1;
            end else begin
              if (~&stat_grants_1) stat_grants_1 <= stat_grants_1 + 1'b1;
            end
`endif
          end
        end

        BCAST: begin
          bus.snoop_valid <= '0;
          wait_cnt        <= '0;
          if (bus.bcast_type) begin
            state <= WAIT;
          end else begin
            state    <= DONE;
            bus.done <= owner_sel;
          end
        end

        // Only the non-owner can answer; a simultaneous hit and miss resolves as a hit.
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (peer_hit) begin
            state            <= DONE;
            bus.done         <= owner_sel;
            bus.hit          <= owner_sel;
            bus.rdata[owner] <= bus.resp_data[peer];
          end else if (peer_miss || wait_cnt == LAST_WAIT) begin
            state    <= DONE;
            bus.done <= owner_sel;
`ifdef SNOOP_ARB_STATS_EN
            if (!peer_miss && ~&stat_timeouts) stat_timeouts <= stat_timeouts + 1'b1;
`endif
          end
        end

        DONE: begin
          state          <= IDLE;
          ptr            <= peer;
          wait_cnt       <= '0;
          bus.done       <= '0;
          bus.hit        <= '0;
          bus.rdata[0]   <= '0;
          bus.rdata[1]   <= '0;
          bus.bcast_addr <= '0;
          bus.bcast_data <= '0;
          bus.bcast_type <= 1'b0;
          bus.busy       <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
